// File: rtl/qspi_psram_responder_pkg.sv
`timescale 1ns/1ps
// Shared types for the QSPI PSRAM responder:
// FSM states, opcodes and line-direction helper.
package spi_types;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    ADDR,
    WAIT,
    WRITE_DATA,
    READ_DATA,
    IGNORE
  } ResponderState;

  localparam logic [7:0] CMD_ENTER_QUAD     = 8'h35;
  localparam logic [7:0] CMD_EXIT_QUAD      = 8'hF5;
  localparam logic [7:0] CMD_QUAD_WRITE     = 8'h38;
  localparam logic [7:0] CMD_FAST_QUAD_READ = 8'hEB;

  typedef enum logic [1:0] {
    SPI_SERIAL_IN,
    SPI_QUAD_IN,
    SPI_QUAD_OUT
  } SpiMode;

  // Only the quad-out direction turns the pads around.
  function automatic logic [3:0] line_oe(input SpiMode m);
    return (m == SPI_QUAD_OUT) ? 4'hF : 4'h0;
  endfunction

endpackage

// File: rtl/qspi_psram_responder_pin_sync.sv
`timescale 1ns/1ps
// Two-flop synchronizer for an asynchronous pin, plus a
// third flop so rise/fall come out as one-clk pulses.
module spi_pin_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_pin,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  // Synchronizer chain; reset parks it at the idle pin level.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= RST_VAL;
      r_s2 <= RST_VAL;
      r_s3 <= RST_VAL;
    end else begin
      r_s1 <= i_pin;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_level = r_s2;
  assign o_rise  = r_s2 & ~r_s3;
  assign o_fall  = ~r_s2 & r_s3;

endmodule

// File: rtl/qspi_psram_responder.sv
`timescale 1ns/1ps
// QSPI PSRAM responder: serial/QPI command decode, quad write
// and fast quad read against a byte-wide backing store.
module qspi_psram_responder
  import spi_types::*;
#(
  parameter int WAIT_CYCLES = 6,
  parameter int ADDR_W      = 24
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              sclk,
  input  logic              cs_n,
  input  logic [3:0]        sio_in,
  output logic [3:0]        sio_out,
  output logic [3:0]        sio_oe,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [7:0]        mem_rdata,
  output logic              quad_mode
);

  localparam logic [7:0] ADDR_LAST = 8'(ADDR_W / 4 - 1);
  localparam logic [7:0] WAIT_LAST = 8'(WAIT_CYCLES - 1);

  logic          w_sclk_rise;
  logic          w_sclk_fall;
  logic          w_unused_sclk_lvl;
  logic          w_cs_lvl;
  logic          w_unused_cs_rise;
  logic          w_unused_cs_fall;
  logic [7:0]    w_cmd_next;
  logic          w_cmd_done;
  logic [7:0]    w_rbyte;

  ResponderState r_state;
  logic [7:0]    r_cnt;
  logic [7:0]    r_cmd;
  logic [7:0]    r_rbyte;
  logic [3:0]    r_wnib;
  logic          r_half;
  logic          r_re_d;
  logic [1:0]    r_warm;
  logic          r_armed;
  logic [ADDR_W-1:0] r_addr;

  spi_pin_sync #(.RST_VAL(1'b0)) u_sclk_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (sclk),
    .o_level (w_unused_sclk_lvl),
    .o_rise  (w_sclk_rise),
    .o_fall  (w_sclk_fall)
  );

  spi_pin_sync #(.RST_VAL(1'b1)) u_cs_sync (
    .clk     (clk),
    .rst     (rst),
    .i_pin   (cs_n),
    .o_level (w_cs_lvl),
    .o_rise  (w_unused_cs_rise),
    .o_fall  (w_unused_cs_fall)
  );

  assign w_cmd_next = quad_mode ? {r_cmd[3:0], sio_in}
                                : {r_cmd[6:0], sio_in[0]};
  assign w_cmd_done = quad_mode ? (r_cnt == 8'd1)
                                : (r_cnt == 8'd7);
  // Read data is only guaranteed the clk after the strobe,
  // so bypass the holding register in that one cycle.
  assign w_rbyte    = r_re_d ? mem_rdata : r_rbyte;
  assign mem_addr   = r_addr;

  // Protocol FSM with registered pad and memory outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_cnt     <= 8'd0;
      r_cmd     <= 8'd0;
      r_rbyte   <= 8'd0;
      r_wnib    <= 4'd0;
      r_half    <= 1'b0;
      r_re_d    <= 1'b0;
      r_warm    <= 2'd0;
      r_armed   <= 1'b0;
      r_addr    <= '0;
      quad_mode <= 1'b0;
      sio_out   <= 4'd0;
      sio_oe    <= 4'd0;
      mem_we    <= 1'b0;
      mem_re    <= 1'b0;
      mem_wdata <= 8'd0;
    end else begin
      mem_we <= 1'b0;
      mem_re <= 1'b0;
      r_re_d <= mem_re;
      if (r_re_d) r_rbyte <= mem_rdata;
      // Arm only after seeing a real cs_n high, so a select
      // held low across reset is not taken as a new frame.
      if (r_warm != 2'd2) r_warm <= r_warm + 2'd1;
      else if (w_cs_lvl) r_armed <= 1'b1;
      if (mem_we) r_addr <= r_addr + ADDR_W'(1);
      if (w_cs_lvl) begin
        r_state <= IDLE;
        r_cnt   <= 8'd0;
        r_half  <= 1'b0;
        sio_oe  <= line_oe(SPI_SERIAL_IN);
      end else begin
        unique case (r_state)
          IDLE: begin
            if (r_armed) begin
              r_state <= CMD;
              r_cnt   <= 8'd0;
              r_half  <= 1'b0;
            end
          end
          CMD: begin
            if (w_sclk_rise) begin
              r_cmd <= w_cmd_next;
              r_cnt <= r_cnt + 8'd1;
              if (w_cmd_done) begin
                r_cnt <= 8'd0;
                case (w_cmd_next)
                  CMD_ENTER_QUAD: begin
                    quad_mode <= 1'b1;
                    r_state   <= IGNORE;
                  end
                  CMD_EXIT_QUAD: begin
                    quad_mode <= 1'b0;
                    r_state   <= IGNORE;
                  end
                  CMD_QUAD_WRITE,
                  CMD_FAST_QUAD_READ: r_state <= ADDR;
                  default:            r_state <= IGNORE;
                endcase
              end
            end
          end
          ADDR: begin
            if (w_sclk_rise) begin
              r_addr <= {r_addr[ADDR_W-5:0], sio_in};
              r_cnt  <= r_cnt + 8'd1;
              if (r_cnt == ADDR_LAST) begin
                r_cnt   <= 8'd0;
                r_half  <= 1'b0;
                r_state <= (r_cmd == CMD_QUAD_WRITE)
                           ? WRITE_DATA : WAIT;
              end
            end
          end
          WAIT: begin
            if (w_sclk_rise) begin
              r_cnt <= r_cnt + 8'd1;
              if (r_cnt == WAIT_LAST) begin
                r_cnt   <= 8'd0;
                r_half  <= 1'b0;
                mem_re  <= 1'b1;
                r_state <= READ_DATA;
              end
            end
          end
          READ_DATA: begin
            if (w_sclk_fall) begin
              if (!r_half) begin
                sio_out <= w_rbyte[7:4];
                sio_oe  <= line_oe(SPI_QUAD_OUT);
                r_half  <= 1'b1;
              end else begin
                sio_out <= w_rbyte[3:0];
                r_addr  <= r_addr + ADDR_W'(1);
                mem_re  <= 1'b1;
                r_half  <= 1'b0;
              end
            end
          end
          WRITE_DATA: begin
            if (w_sclk_rise) begin
              if (!r_half) begin
                r_wnib <= sio_in;
                r_half <= 1'b1;
              end else begin
                mem_wdata <= {r_wnib, sio_in};
                mem_we    <= 1'b1;
                r_half    <= 1'b0;
              end
            end
          end
          IGNORE: begin
            r_cnt <= 8'd0;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_qspi_psram_responder.sv
`timescale 1ns/1ps
// Self-checking bench for qspi_psram_responder: drives QSPI
// frames and compares against a byte-array memory model.
module tb_qspi_psram_responder;

  localparam int WAITC = 6;
  localparam int AW    = 24;
  localparam int HALF  = 50;

  logic          clk = 1'b0;
  logic          rst;
  logic          sclk;
  logic          cs_n;
  logic [3:0]    sio_in;
  logic [3:0]    sio_out;
  logic [3:0]    sio_oe;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_wdata;
  logic          mem_we;
  logic          mem_re;
  logic [7:0]    mem_rdata;
  logic          quad_mode;

  always #5 clk = ~clk;

  qspi_psram_responder #(.WAIT_CYCLES(WAITC), .ADDR_W(AW)) dut (
    .clk       (clk),
    .rst       (rst),
    .sclk      (sclk),
    .cs_n      (cs_n),
    .sio_in    (sio_in),
    .sio_out   (sio_out),
    .sio_oe    (sio_oe),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .mem_we    (mem_we),
    .mem_re    (mem_re),
    .mem_rdata (mem_rdata),
    .quad_mode (quad_mode)
  );

  int total = 0;
  int bad = 0;
  int re_cnt = 0;
  int coinc = 0;
  int oe_err = 0;
  bit m_quad = 1'b0;
  logic [31:0] wq[$];
  logic [31:0] exp_wq[$];
  logic [7:0]  store[int];
  logic [7:0]  ref_mem[int];
  logic [3:0]  rd_nib[$];
  logic [3:0]  rd_oe[$];

  // Backing store: read data valid only the clk after mem_re.
  always @(posedge clk) begin
    if (mem_we) begin
      store[int'(mem_addr)] = mem_wdata;
      wq.push_back({mem_addr, mem_wdata});
    end
    if (mem_re) begin
      re_cnt++;
      mem_rdata <= store.exists(int'(mem_addr))
                   ? store[int'(mem_addr)] : 8'h00;
    end else begin
      mem_rdata <= 8'($urandom);
    end
    if (mem_we && mem_re) coinc++;
  end

  function automatic logic [3:0] exp_nib(
    input logic [23:0] a, input int j);
    logic [23:0] ra;
    logic [7:0]  b;
    ra = 24'((int'(a) + j / 2) % 16777216);
    b = ref_mem.exists(int'(ra)) ? ref_mem[int'(ra)] : 8'h00;
    return (j % 2 == 0) ? b[7:4] : b[3:0];
  endfunction

  task automatic sck(input logic [3:0] d,
                     output logic [3:0] o,
                     output logic [3:0] oe);
    sio_in = d;
    #(HALF);
    o  = sio_out;
    oe = sio_oe;
    sclk = 1'b1;
    #(HALF);
    sclk = 1'b0;
  endtask

  task automatic sck_in(input logic [3:0] d);
    logic [3:0] o, oe;
    sck(d, o, oe);
    if (oe != 4'h0) oe_err++;
  endtask

  task automatic begin_xfer();
    cs_n = 1'b0;
    #40;
  endtask

  task automatic end_xfer();
    #(HALF);
    cs_n = 1'b1;
    #200;
  endtask

  task automatic send_cmd(input logic [7:0] op);
    if (m_quad) begin
      sck_in(op[7:4]);
      sck_in(op[3:0]);
    end else begin
      for (int i = 7; i >= 0; i--) sck_in({3'b000, op[i]});
    end
  endtask

  task automatic send_addr(input logic [23:0] a);
    for (int i = 5; i >= 0; i--) sck_in(a[i*4 +: 4]);
  endtask

  task automatic do_write(input logic [23:0] a,
                          input logic [7:0] d[$],
                          input bit extra);
    logic [23:0] wa;
    begin_xfer();
    send_cmd(8'h38);
    send_addr(a);
    foreach (d[i]) begin
      sck_in(d[i][7:4]);
      sck_in(d[i][3:0]);
      wa = 24'((int'(a) + i) % 16777216);
      ref_mem[int'(wa)] = d[i];
      exp_wq.push_back({wa, d[i]});
    end
    if (extra) sck_in(4'($urandom));
    end_xfer();
  endtask

  task automatic do_read(input logic [23:0] a, input int n);
    logic [3:0] o, oe;
    rd_nib.delete();
    rd_oe.delete();
    begin_xfer();
    send_cmd(8'hEB);
    send_addr(a);
    repeat (WAITC) sck_in(4'($urandom));
    for (int j = 0; j < 2 * n; j++) begin
      sck(4'($urandom), o, oe);
      rd_nib.push_back(o);
      rd_oe.push_back(oe);
    end
    end_xfer();
  endtask

  task automatic test_reset();
    rst = 1'b1; cs_n = 1'b1; sclk = 1'b0; sio_in = 4'h0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    total++;
    if (quad_mode !== 1'b0) begin
      bad++; $display("FAIL reset_quad got=%b exp=0", quad_mode);
    end
    total++;
    if (sio_oe !== 4'h0 || sio_out !== 4'h0) begin
      bad++;
      $display("FAIL reset_pads got oe=%h out=%h exp 0/0",
               sio_oe, sio_out);
    end
    total++;
    if ({mem_we, mem_re} !== 2'b00) begin
      bad++; $display("FAIL reset_strobes got=%b exp=00",
                      {mem_we, mem_re});
    end
    total++;
    if (mem_addr !== 24'h0 || mem_wdata !== 8'h0) begin
      bad++;
      $display("FAIL reset_mem got addr=%h wdata=%h exp 0/0",
               mem_addr, mem_wdata);
    end
    rst = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_quad_mode();
    begin_xfer(); send_cmd(8'h35); end_xfer();
    m_quad = 1'b1;
    total++;
    if (quad_mode !== m_quad) begin
      bad++; $display("FAIL quad_enter got=%b exp=%b",
                      quad_mode, m_quad);
    end
    begin_xfer(); send_cmd(8'hF5); end_xfer();
    m_quad = 1'b0;
    total++;
    if (quad_mode !== m_quad) begin
      bad++; $display("FAIL quad_exit got=%b exp=%b",
                      quad_mode, m_quad);
    end
    begin_xfer(); send_cmd(8'h35); end_xfer();
    m_quad = 1'b1;
    total++;
    if (quad_mode !== m_quad) begin
      bad++; $display("FAIL quad_reenter got=%b exp=%b",
                      quad_mode, m_quad);
    end
  endtask

  task automatic test_write_read(input string tag,
                                 input logic [23:0] a,
                                 input logic [7:0] d[$],
                                 input bit extra);
    int re0;
    int oe0;
    wq.delete();
    exp_wq.delete();
    oe0 = oe_err;
    do_write(a, d, extra);
    total++;
    if (wq.size() != exp_wq.size()) begin
      bad++;
      $display("FAIL %s_wr_count got=%0d exp=%0d",
               tag, wq.size(), exp_wq.size());
    end else begin
      foreach (exp_wq[k]) begin
        total++;
        if (wq[k] !== exp_wq[k]) begin
          bad++;
          $display("FAIL %s_wr%0d got=%h exp=%h",
                   tag, k, wq[k], exp_wq[k]);
        end
      end
    end
    re0 = re_cnt;
    do_read(a, d.size());
    for (int j = 0; j < 2 * d.size(); j++) begin
      total++;
      if (rd_nib[j] !== exp_nib(a, j) || rd_oe[j] !== 4'hF) begin
        bad++;
        $display("FAIL %s_rd%0d got=%h oe=%h exp=%h oe=f",
                 tag, j, rd_nib[j], rd_oe[j], exp_nib(a, j));
      end
    end
    total++;
    if (re_cnt - re0 != d.size() + 1) begin
      bad++;
      $display("FAIL %s_re_count got=%0d exp=%0d",
               tag, re_cnt - re0, d.size() + 1);
    end
    total++;
    if (oe_err != oe0 || sio_oe !== 4'h0) begin
      bad++;
      $display("FAIL %s_oe_idle got=%0d/%h exp=%0d/0",
               tag, oe_err, sio_oe, oe0);
    end
  endtask

  task automatic test_write_basic();
    logic [7:0] d[$];
    d = '{8'hA5, 8'h3C};
    test_write_read("basic", 24'h000010, d, 1'b0);
  endtask

  task automatic test_wrap();
    logic [7:0] d[$];
    d = '{8'($urandom), 8'($urandom)};
    test_write_read("wrap", 24'hFFFFFF, d, 1'b0);
  endtask

  task automatic test_partial();
    logic [7:0] d[$];
    d = '{8'($urandom)};
    test_write_read("partial", 24'($urandom), d, 1'b1);
  endtask

  task automatic test_unknown_opcode();
    logic [7:0] op;
    int w0, r0, o0;
    do op = 8'($urandom);
    while (op == 8'h35 || op == 8'hF5 ||
           op == 8'h38 || op == 8'hEB);
    w0 = wq.size(); r0 = re_cnt; o0 = oe_err;
    begin_xfer();
    send_cmd(op);
    repeat (6) sck_in(4'($urandom));
    end_xfer();
    total++;
    if (wq.size() != w0 || re_cnt != r0) begin
      bad++;
      $display("FAIL unknown_op_%h got we=%0d re=%0d exp 0/0",
               op, wq.size() - w0, re_cnt - r0);
    end
    total++;
    if (quad_mode !== m_quad || oe_err != o0) begin
      bad++;
      $display("FAIL unknown_op_state got q=%b oe=%0d exp q=%b",
               quad_mode, oe_err - o0, m_quad);
    end
  endtask

  task automatic test_random();
    logic [7:0]  d[$];
    logic [23:0] a;
    int n;
    for (int it = 0; it < 5; it++) begin
      a = ($urandom_range(0, 2) == 0) ? 24'hFFFFFE : 24'($urandom);
      n = $urandom_range(1, 4);
      d.delete();
      repeat (n) d.push_back(8'($urandom));
      test_write_read($sformatf("rand%0d", it), a, d, 1'b0);
    end
  endtask

  task automatic test_reset_mid_read();
    logic [3:0] o, oe;
    int re0;
    begin_xfer();
    send_cmd(8'hEB);
    send_addr(24'h000010);
    repeat (WAITC) sck_in(4'($urandom));
    sck(4'h0, o, oe);
    sck(4'h0, o, oe);
    total++;
    if (sio_oe !== 4'hF) begin
      bad++; $display("FAIL rstmid_pre_oe got=%h exp=f", sio_oe);
    end
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (sio_oe !== 4'h0 || quad_mode !== 1'b0) begin
      bad++;
      $display("FAIL rstmid_abort got oe=%h q=%b exp 0/0",
               sio_oe, quad_mode);
    end
    rst = 1'b0;
    m_quad = 1'b0;
    re0 = re_cnt;
    repeat (4) sck(4'($urandom), o, oe);
    total++;
    if (re_cnt != re0 || sio_oe !== 4'h0) begin
      bad++;
      $display("FAIL rstmid_quiet got re=%0d oe=%h exp 0/0",
               re_cnt - re0, sio_oe);
    end
    end_xfer();
    begin_xfer(); send_cmd(8'h35); end_xfer();
    m_quad = 1'b1;
    total++;
    if (quad_mode !== m_quad) begin
      bad++; $display("FAIL rstmid_recover got=%b exp=%b",
                      quad_mode, m_quad);
    end
  endtask

  task automatic test_coincident();
    total++;
    if (coinc != 0) begin
      bad++; $display("FAIL we_re_same_clk got=%0d exp=0", coinc);
    end
  endtask

  initial begin
    test_reset();
    test_quad_mode();
    test_write_basic();
    test_wrap();
    test_partial();
    test_unknown_opcode();
    test_random();
    test_reset_mid_read();
    test_coincident();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/qspi_psram_responder.md
QSPI_PSRAM_RESPONDER -- requirements
Module: qspi_psram_responder

Interface
REQ-001 Parameter WAIT_CYCLES, default 6: dummy sclk cycles between the last address nibble and the first read-data nibble of 0xEB.
REQ-002 Parameter ADDR_W, default 24: address width carried on the bus.
REQ-003 clk  in  1  single system clock; every flop clocks on its rising edge.
REQ-004 rst  in  1  synchronous, active-high reset.
REQ-005 sclk  in  1  QSPI clock from the initiator, asynchronous to clk, at most clk/4.
REQ-006 cs_n  in  1  chip select, active low, asynchronous.
REQ-007 sio_in  in  4  sampled data lines; bit 0 is SI in serial mode.
REQ-008 sio_out  out  4  driven data lines.
REQ-009 sio_oe  out  4  per-line output enable.
REQ-010 mem_addr  out  ADDR_W  byte address for the backing store.
REQ-011 mem_wdata  out  8  write byte.
REQ-012 mem_we  out  1  one-clk write strobe.
REQ-013 mem_re  out  1  one-clk read strobe.
REQ-014 mem_rdata  in  8  read byte, valid exactly one clk after mem_re.
REQ-015 quad_mode  out  1  high while QPI mode is active.

Function
REQ-016 sclk and cs_n SHALL pass through 2-flop synchronizers, with a third flop for edge detection; "rise" and "fall" are one-clk pulses.
REQ-017 sio_in SHALL be captured on rise; sio_out SHALL change only on fall.
REQ-018 States: IDLE, CMD, ADDR, WAIT, WRITE_DATA, READ_DATA, IGNORE.
REQ-019 Leaving IDLE: cs_n low moves IDLE to CMD with the bit/nibble counter cleared.
REQ-020 Deasserting cs_n: in any state, a synchronized cs_n high SHALL force IDLE, sio_oe=0 and counter clear on the same clk.
REQ-021 CMD serial: 8 rises, MSB first, on sio_in[0].
REQ-022 CMD quad: when quad_mode=1, 2 rises, high nibble first.
REQ-023 Command decode: 0x35 sets quad_mode at cmd end, then IGNORE.
REQ-024 Command decode: 0xF5 clears quad_mode at cmd end, then IGNORE.
REQ-025 Command decode: 0x38 and 0xEB go to ADDR.
REQ-026 Command decode: any other opcode goes to IGNORE.
REQ-027 ADDR: ADDR_W/4 rises, quad, high nibble first.
REQ-028 ADDR exit: 0x38 goes to WRITE_DATA; 0xEB goes to WAIT.
REQ-029 WAIT: WAIT_CYCLES rises ignored; mem_re pulses on the clk after the final wait rise.
REQ-030 READ_DATA: first nibble is mem_rdata[7:4] on the next fall; sio_oe=4'hF from that fall until cs_n high.
REQ-031 READ_DATA streaming: [3:0] on the following fall; mem_re for addr+1 issues on the fall that drives [3:0], so the next byte is ready.
REQ-032 WRITE_DATA: two rises form a byte, high nibble first; mem_we pulses one clk after the second rise with mem_addr at the current address.
REQ-033 Address increment: the address increments by 1 after each completed byte and wraps 2^ADDR_W-1 to 0.
REQ-034 Partial byte: a lone nibble at cs_n high SHALL be discarded with no mem_we.
REQ-035 Serial-output lines: sio_oe SHALL be 0 in all states except READ_DATA.
REQ-036 Coincident edges: mem_we and mem_re SHALL never pulse in the same clk.

Reset
REQ-037 rst SHALL, within one clk, set IDLE, quad_mode=0, sio_out=0, sio_oe=0, mem_we=0, mem_re=0, mem_addr=0, mem_wdata=0, and clear counters and synchronizers (cs_n sync to 1, sclk sync to 0).
REQ-038 rst mid-transfer SHALL abort with no further mem strobes; the responder then waits for a cs_n high-to-low edge.

Structure
REQ-039 Package spi_types SHALL hold: ResponderState enum (REQ-018), opcode constants CMD_ENTER_QUAD=0x35, CMD_EXIT_QUAD=0xF5, CMD_QUAD_WRITE=0x38, CMD_FAST_QUAD_READ=0xEB, and the existing SpiMode reused for line direction.
REQ-040 One sub-module spi_pin_sync (synchronizer plus rise/fall detect) SHALL be instantiated for sclk and cs_n.

Verification
REQ-041 Serial 0x35 then cs_n high -> quad_mode=1; a quad 0xF5 -> quad_mode=0.
REQ-042 Quad 0x38, addr 0x000010, data A5 3C -> mem_we twice: (0x10,A5), (0x11,3C).
REQ-043 Quad 0xEB, addr 0x000010, 6 waits, backing store 0x10=A5/0x11=3C -> sio_out nibbles A,5,3,C; sio_oe=F only during data.
REQ-044 0x38 at addr 0xFFFFFF with 2 bytes -> writes to 0xFFFFFF then 0x000000.
REQ-045 cs_n high after 3 write nibbles -> one mem_we only; next command decodes normally.
REQ-046 rst asserted during READ_DATA -> sio_oe=0 next clk, no mem_re afterwards, quad_mode=0.
